// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module : fsm_pkg
//  Shared 2-bit state encoding for the sequence detectors and pattern generator.
//  Rev    : 1.0  initial release
// ============================================================================
package fsm_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_GAP   = GAP,
    ST_DONE  = DONE
  } state_t;

  // Counter width helper: a zero-width counter is never allowed.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_piso.sv
`default_nettype none
// ============================================================================
//  Module : seq_piso
//  Loadable parallel-in serial-out shift register, MSB out first, zero fill.
//  Rev    : 1.0  initial release
// ============================================================================
module seq_piso #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             sout
);

  logic [PAT_W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (load) begin
      r_sr <= din;
    end else if (shift) begin
      r_sr <= r_sr << 1;
    end
  end

  assign sout = r_sr[PAT_W-1];

endmodule
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module : seq_pattern_gen
//  Serial pattern transmitter: PAT_W-bit pattern, MSB first, repeated with gaps.
//  Rev    : 1.0  initial release
// ============================================================================
module seq_pattern_gen
  import fsm_pkg::*;
#(
  parameter int PAT_W   = 3,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned c_IDX_W   = clog2_min1(PAT_W);
  localparam int unsigned c_GAP_W   = clog2_min1(GAP_CYC + 1);
  localparam bit          c_HAS_GAP = (GAP_CYC > 0);
  localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(PAT_W - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_HAS_GAP ? GAP_CYC - 1 : 0);

  state_t             r_state;
  state_t             w_nxt;
  logic [c_IDX_W-1:0] r_idx;
  logic [CNT_W-1:0]   r_rem;
  logic [c_GAP_W-1:0] r_gap;
  logic [PAT_W-1:0]   r_pat;

  logic               w_load;
  logic               w_shift;
  logic [PAT_W-1:0]   w_din;

  // The shift register holds the bit being sent in its MSB; it is loaded with
  // zero whenever no bit follows, so its output doubles as the registered bit_out.
  always_comb begin
    w_nxt   = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_din   = r_pat;
    case (r_state)
      ST_IDLE: begin
        if (start_valid) begin
          w_load = 1'b1;
          if (repeat_cnt == '0) begin
            w_nxt = ST_DONE;
            w_din = '0;
          end else begin
            w_nxt = ST_SHIFT;
            w_din = pattern;
          end
        end
      end
      ST_SHIFT: begin
        if (r_idx != '0) begin
          w_shift = 1'b1;
        end else begin
          w_load = 1'b1;
          if (r_rem == CNT_W'(1)) begin
            w_nxt = ST_DONE;
            w_din = '0;
          end else if (c_HAS_GAP) begin
            w_nxt = ST_GAP;
            w_din = '0;
          end else begin
            w_nxt = ST_SHIFT;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          w_nxt  = ST_SHIFT;
          w_load = 1'b1;
        end
      end
      ST_DONE: begin
        w_nxt = ST_IDLE;
      end
      default: begin
        w_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_rem       <= '0;
      r_gap       <= '0;
      r_pat       <= '0;
      start_ready <= 1'b1;
      bit_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      start_ready <= (w_nxt == ST_IDLE);
      bit_valid   <= (w_nxt == ST_SHIFT);
      busy        <= (w_nxt != ST_IDLE);
      done        <= (w_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_pat <= pattern;
            r_rem <= repeat_cnt;
            r_idx <= c_IDX_MAX;
          end
        end
        ST_SHIFT: begin
          if (r_idx != '0) begin
            r_idx <= r_idx - 1'b1;
          end else begin
            // remaining is at least 1 here, so this decrement cannot wrap
            r_idx <= c_IDX_MAX;
            r_rem <= r_rem - 1'b1;
            r_gap <= c_GAP_LAST;
          end
        end
        ST_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  seq_piso #(
    .PAT_W (PAT_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .sout  (bit_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module : tb_seq_pattern_gen
//  Bench for seq_pattern_gen: GAP_CYC=2 and GAP_CYC=0 instances against a queue model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_seq_pattern_gen;

  localparam int PW = 3;
  localparam int CW = 4;
  // observation vector: {start_ready, bit_valid, bit_out, busy, done}
  localparam logic [4:0] IDLE_OBS = 5'b10000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_valid = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [CW-1:0] repeat_cnt = '0;

  logic rdy2, bo2, bv2, busy2, done2;
  logic rdy0, bo0, bv0, busy0, done0;

  int checks = 0;
  int fails  = 0;
  bit armed  = 1'b0;

  logic [4:0] q2[$];
  logic [4:0] q0[$];
  bit idle2, idle0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PW), .CNT_W(CW), .GAP_CYC(2)) dut2 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(rdy2),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .bit_out(bo2), .bit_valid(bv2),
    .busy(busy2), .done(done2)
  );

  seq_pattern_gen #(.PAT_W(PW), .CNT_W(CW), .GAP_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(rdy0),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .bit_out(bo0), .bit_valid(bv0),
    .busy(busy0), .done(done0)
  );

  // Model: each queue holds the expected observation for the current cycle at
  // its head; an accept appends the whole burst computed from the rules.
  always @(posedge clk) begin
    if (reset) begin
      q2.delete();
      q0.delete();
      armed = 1'b1;
    end else begin
      idle2 = (q2.size() == 0);
      idle0 = (q0.size() == 0);
      if (!idle2) void'(q2.pop_front());
      if (!idle0) void'(q0.pop_front());
      if (idle2 && start_valid) begin
        for (int r = 0; r < int'(repeat_cnt); r++) begin
          for (int i = PW - 1; i >= 0; i--) q2.push_back({1'b0, 1'b1, pattern[i], 1'b1, 1'b0});
          if (r < int'(repeat_cnt) - 1)
            for (int g = 0; g < 2; g++) q2.push_back(5'b00010);
        end
        q2.push_back(5'b00011);
      end
      if (idle0 && start_valid) begin
        for (int r = 0; r < int'(repeat_cnt); r++)
          for (int i = PW - 1; i >= 0; i--) q0.push_back({1'b0, 1'b1, pattern[i], 1'b1, 1'b0});
        q0.push_back(5'b00011);
      end
    end
  end

  logic [4:0] e2, e0, a2, a0;
  always @(negedge clk) begin
    if (armed) begin
      e2 = (q2.size() != 0) ? q2[0] : IDLE_OBS;
      e0 = (q0.size() != 0) ? q0[0] : IDLE_OBS;
      a2 = {rdy2, bv2, bo2, busy2, done2};
      a0 = {rdy0, bv0, bo0, busy0, done0};
      checks += 2;
      if (a2 !== e2) begin
        fails++;
        $display("FAIL cyc_gap2 t=%0t got=%b expected=%b (rdy,valid,bit,busy,done)", $time, a2, e2);
      end
      if (a0 !== e0) begin
        fails++;
        $display("FAIL cyc_gap0 t=%0t got=%b expected=%b (rdy,valid,bit,busy,done)", $time, a0, e0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Accept with the current inputs; returns just after the accept edge T.
  task automatic request(input logic [PW-1:0] p, input logic [CW-1:0] r);
    pattern     = p;
    repeat_cnt  = r;
    start_valid = 1'b1;
    next_cycle();
    start_valid = 1'b0;
  endtask

  // Samples cycles T+1..T+n, earliest cycle ends up leftmost.
  logic [31:0] v2, b2, d2, s2, k2, v0, b0, d0;
  task automatic record(input int n);
    v2 = '0; b2 = '0; d2 = '0; s2 = '0; k2 = '0; v0 = '0; b0 = '0; d0 = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v2 = {v2[30:0], bv2}; b2 = {b2[30:0], bo2}; d2 = {d2[30:0], done2};
      s2 = {s2[30:0], rdy2}; k2 = {k2[30:0], busy2};
      v0 = {v0[30:0], bv0}; b0 = {b0[30:0], bo0}; d0 = {d0[30:0], done0};
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy2 && rdy0) begin
        next_cycle();
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL wait_idle got=busy expected=idle within 200 cycles");
    next_cycle();
  endtask

  initial begin
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {27'd0, rdy2, bv2, bo2, busy2, done2}, {27'd0, IDLE_OBS});
    next_cycle();

    request(3'b110, 4'd1);
    record(5);
    check("r1_valid", v2, 32'b11100);
    check("r1_bits",  b2, 32'b11000);
    check("r1_done",  d2, 32'b00010);
    check("r1_ready", s2, 32'b00001);
    wait_idle();

    request(3'b110, 4'd3);
    record(15);
    check("r3_valid", v2, 32'b111001110011100);
    check("r3_bits",  b2, 32'b110001100011000);
    check("r3_done",  d2, 32'b000000000000010);
    check("r3_busy",  k2, 32'b111111111111110);
    wait_idle();

    request(3'b110, 4'd0);
    record(2);
    check("r0_valid", v2, 32'b00);
    check("r0_done",  d2, 32'b10);
    check("r0_ready", s2, 32'b01);
    wait_idle();

    request(3'b101, 4'd2);
    record(8);
    check("g0_bits",  b0, 32'b10110100);
    check("g0_valid", v0, 32'b11111100);
    check("g0_done",  d0, 32'b00000010);
    wait_idle();

    // start_valid held high, pattern changed during the first burst
    pattern = 3'b110; repeat_cnt = 4'd1; start_valid = 1'b1;
    next_cycle();
    fork
      begin next_cycle(); pattern = 3'b011; end
    join_none
    record(9);
    start_valid = 1'b0;
    check("hold_bits",  b2, 32'b110000110);
    check("hold_valid", v2, 32'b111001110);
    check("hold_done",  d2, 32'b000100001);
    wait_idle();

    // reset during the second bit
    request(3'b110, 4'd2);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    record(4);
    check("abort_valid", v2, 32'b0000);
    check("abort_busy",  k2, 32'b0000);
    check("abort_ready", s2, 32'b1111);
    check("abort_done",  d2, 32'b0000);

    request(3'b011, 4'd1);
    record(4);
    check("after_abort_bits", b2, 32'b0110);
    check("after_abort_done", d2, 32'b0001);
    wait_idle();

    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      start_valid = ($urandom_range(0, 2) != 0);
      pattern     = PW'($urandom);
      repeat_cnt  = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
      next_cycle();
    end
    reset = 1'b0;
    start_valid = 1'b0;
    wait_idle();
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
